// File: rtl/mac_seq_if.sv
// ---------------------------------------------------------------------------
// mac_seq_if
//   Operand/result bundle for the sequential multiply-accumulate unit.
//
//   Parameters
//     WIDTH      operand width of a and b
//     ACC_WIDTH  width of c, the accumulator and the result
//
//   Signals
//     in_valid / in_ready    operand-side handshake
//     a, b                   unsigned multiplicand / multiplier
//     c                      unsigned external addend
//     acc_mode               0: addend = c, 1: addend = internal accumulator
//     acc_clr                clear accumulator and sticky overflow (idle only)
//     out_valid / out_ready  result-side handshake
//     out                    result
//     out_ovf                this result carried out of ACC_WIDTH
//     ovf_sticky             any overflow since reset / last acc_clr
//
//   Modports
//     master  the side that issues operands and consumes results
//     slave   the mac_seq unit itself
// ---------------------------------------------------------------------------
interface mac_seq_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [ACC_WIDTH-1:0] c;
    logic                 acc_mode;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out;
    logic                 out_ovf;
    logic                 ovf_sticky;

    modport master (
        output in_valid, a, b, c, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, out, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, c, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, out, out_ovf, ovf_sticky
    );

endinterface : mac_seq_if

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq
//   Sequential multiply-accumulate: out = a*b + addend, where the addend is
//   either the external c or the internal accumulator (per transaction).
//   The product is built by a shift-add multiplier that consumes one bit of
//   b per cycle, LSB first, so every transaction takes the same time:
//     IDLE (accept) -> MUL x WIDTH -> ADD -> DONE (until out_ready)
//   With out_ready held high a new operand set is accepted every WIDTH+3
//   cycles; transactions never overlap.
//
//   Ports
//     clk   clock, all state changes on the rising edge
//     rst   synchronous, active-high reset
//     bus   mac_seq_if.slave (operand/result handshakes, see mac_seq_if)
//
//   Parameters
//     WIDTH      operand width (>= 2)
//     ACC_WIDTH  addend/accumulator/result width (>= 2*WIDTH)
//
//   Build option
//     MAC_SAT_EN  when defined, a carry out of ACC_WIDTH forces the result
//                 and the accumulator to all-ones instead of wrapping.
//                 out_ovf and ovf_sticky report the carry either way.
// ---------------------------------------------------------------------------
module mac_seq #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    mac_seq_if.slave   bus
);

    // The product is 2*WIDTH bits and is kept in its own register; it can
    // never overflow because ACC_WIDTH is at least that wide.
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int EXT_W  = ACC_WIDTH + 1 - PROD_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Reject configurations the datapath cannot represent.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("mac_seq: WIDTH must be >= 2");
        end
        if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
            $error("mac_seq: ACC_WIDTH must be >= 2*WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic                 accept_s;
    logic [PROD_W-1:0]    mcand_r;      // a, shifted left once per MUL cycle
    logic [WIDTH-1:0]     mplier_r;     // b, shifted right once per MUL cycle
    logic [PROD_W-1:0]    product_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [ACC_WIDTH-1:0] addend_r;
    logic [ACC_WIDTH-1:0] acc_r;

    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [ACC_WIDTH-1:0] out_r;
    logic                 out_ovf_r;
    logic                 ovf_sticky_r;

    logic [ACC_WIDTH-1:0] addend_sel_s;
    logic [PROD_W-1:0]    partial_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 carry_s;
    logic [ACC_WIDTH-1:0] result_s;

    // Operands are taken only while idle; in_ready is high exactly in IDLE.
    assign accept_s = (state_r == ST_IDLE) && bus.in_valid;

    // Next-state logic for the IDLE/MUL/ADD/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_ADD: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Addend chosen at acceptance; a simultaneous acc_clr makes the
    // accumulator read as zero for this very transaction.
    always_comb begin
        addend_sel_s = {ACC_WIDTH{1'b0}};
        if (bus.acc_mode) begin
            if (bus.acc_clr) begin
                addend_sel_s = {ACC_WIDTH{1'b0}};
            end else begin
                addend_sel_s = acc_r;
            end
        end else begin
            addend_sel_s = bus.c;
        end
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        partial_s = product_r;
        if (mplier_r[0]) begin
            partial_s = product_r + mcand_r;
        end else begin
            partial_s = product_r;
        end
    end

    // Final addition one bit wider than the result so the carry is visible.
    always_comb begin
        sum_s    = {{EXT_W{1'b0}}, product_r} + {1'b0, addend_r};
        carry_s  = sum_s[ACC_WIDTH];
        result_s = sum_s[ACC_WIDTH-1:0];
`ifdef MAC_SAT_EN
        if (carry_s) begin
            result_s = {ACC_WIDTH{1'b1}};
        end else begin
            result_s = sum_s[ACC_WIDTH-1:0];
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered handshake outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Multiplier datapath: operand capture and the WIDTH shift-add steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {PROD_W{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            product_r <= {PROD_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            addend_r  <= {ACC_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r   <= {{WIDTH{1'b0}}, bus.a};
                        mplier_r  <= bus.b;
                        product_r <= {PROD_W{1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
                        addend_r  <= addend_sel_s;
                    end
                end
                ST_MUL: begin
                    product_r <= partial_s;
                    mcand_r   <= {mcand_r[PROD_W-2:0], 1'b0};
                    mplier_r  <= {1'b0, mplier_r[WIDTH-1:1]};
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
                ST_ADD, ST_DONE: begin
                    // datapath holds until the next acceptance
                end
                default: begin
                    product_r <= {PROD_W{1'b0}};
                end
            endcase
        end
    end

    // Result, accumulator and overflow flags. acc_clr only acts in IDLE;
    // out/out_ovf change only in ADD, so they hold through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r        <= {ACC_WIDTH{1'b0}};
            out_ovf_r    <= 1'b0;
            acc_r        <= {ACC_WIDTH{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.acc_clr) begin
                        acc_r        <= {ACC_WIDTH{1'b0}};
                        ovf_sticky_r <= 1'b0;
                    end
                end
                ST_ADD: begin
                    out_r        <= result_s;
                    out_ovf_r    <= carry_s;
                    acc_r        <= result_s;
                    ovf_sticky_r <= ovf_sticky_r | carry_s;
                end
                ST_MUL, ST_DONE: begin
                    // acc_clr and input changes have no effect here
                end
                default: begin
                    out_ovf_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out        = out_r;
    assign bus.out_ovf    = out_ovf_r;
    assign bus.ovf_sticky = ovf_sticky_r;

endmodule : mac_seq

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq
//   Scoreboard bench for mac_seq (WIDTH=32, ACC_WIDTH=64). The driver
//   computes each expected result from plain arithmetic (a*b + addend,
//   carry = sum >= 2^64) and queues it; a monitor pops and compares on every
//   out_valid && out_ready.
// ---------------------------------------------------------------------------
module tb_mac_seq;

    localparam int WIDTH = 32;
    localparam int ACC_W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_seq_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) bus ();

    mac_seq #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ACC_W-1:0] out;
        logic             ovf;
        logic             sticky;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    logic [ACC_W-1:0] m_acc;
    logic             m_sticky;

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: the accumulator and sticky flag as plain variables.
    task automatic model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [ACC_W-1:0] c, input logic mode,
                              input logic clr);
        logic [ACC_W-1:0] addend;
        logic [ACC_W-1:0] prod;
        logic [ACC_W:0]   full;
        exp_t             e;
        if (clr) begin
            m_acc    = '0;
            m_sticky = 1'b0;
        end
        addend = mode ? m_acc : c;
        prod   = ACC_W'(a) * ACC_W'(b);
        full   = {1'b0, prod} + {1'b0, addend};
        e.ovf  = full[ACC_W];
        e.out  = full[ACC_W-1:0];
`ifdef MAC_SAT_EN
        if (e.ovf) e.out = '1;
`endif
        m_acc    = e.out;
        m_sticky = m_sticky | e.ovf;
        e.sticky = m_sticky;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%h expected none", bus.out);
            end else begin
                mon_e = sb_q.pop_front();
                check("out", bus.out, mon_e.out);
                check_bit("out_ovf", bus.out_ovf, mon_e.ovf);
                check_bit("ovf_sticky", bus.ovf_sticky, mon_e.sticky);
            end
        end
    end

    // Called at a negedge: wait for in_ready, present operands for one edge.
    task automatic drive_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [ACC_W-1:0] c, input logic mode,
                                input logic clr);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.acc_mode = mode;
        bus.acc_clr  = clr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs while busy; they must be ignored
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.c        = {$urandom, $urandom};
        bus.acc_mode = 1'($urandom_range(0, 1));
    endtask

    // Called at the negedge after acceptance. Checks latency, then holds
    // out_ready low for 'hold' cycles checking the result stays put.
    task automatic wait_result(input int hold);
        int               after = 0;
        logic [ACC_W-1:0] held_out;
        logic             held_ovf;
        logic             held_sticky;
        bus.out_ready = (hold == 0);
        while (!bus.out_valid && after < 200) begin
            @(posedge clk);
            @(negedge clk);
            after++;
        end
        // counting the acceptance edge itself, out_valid is high after WIDTH+2 edges
        check("latency_edges", ACC_W'(after + 1), ACC_W'(WIDTH + 2));
        held_out    = bus.out;
        held_ovf    = bus.out_ovf;
        held_sticky = bus.ovf_sticky;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.acc_clr  = 1'b1;
            bus.a        = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_bit("hold_out_valid", bus.out_valid, 1'b1);
            check_bit("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out", bus.out, held_out);
            check_bit("hold_out_ovf", bus.out_ovf, held_ovf);
            check_bit("hold_sticky", bus.ovf_sticky, held_sticky);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b0;
            bus.acc_clr   = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [ACC_W-1:0] c, input logic mode,
                       input logic clr, input int hold);
        model_push(a, b, c, mode, clr);
        drive_accept(a, b, c, mode, clr);
        wait_result(hold);
    endtask

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.acc_mode  = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        m_acc         = '0;
        m_sticky      = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out", bus.out, 64'h0);
        check_bit("rst_out_ovf", bus.out_ovf, 1'b0);
        check_bit("rst_sticky", bus.ovf_sticky, 1'b0);

        // directed cases
        txn(32'd1, 32'd2, 64'd3, 1'b0, 1'b0, 0);
        txn(32'hFFFF_FFFE, 32'd2, 64'd0, 1'b0, 1'b0, 0);
        txn(32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0);
        txn(32'd3, 32'd5, 64'd5, 1'b0, 1'b0, 0);
        txn(32'd2, 32'd3, 64'd0, 1'b1, 1'b0, 0);
        txn(32'd2, 32'd3, 64'hDEAD, 1'b1, 1'b1, 0);
        txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0002_0000_0000, 1'b0, 1'b0, 0);
        check_bit("sticky_after_ovf", bus.ovf_sticky, 1'b1);

        // acc_clr alone in IDLE clears the sticky flag
        @(posedge clk);
        @(negedge clk);
        bus.acc_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.acc_clr = 1'b0;
        m_acc       = '0;
        m_sticky    = 1'b0;
        check_bit("sticky_cleared", bus.ovf_sticky, 1'b0);
        txn(32'd0, 32'd0, 64'd0, 1'b1, 1'b0, 0);

        // output hold for 5 cycles, then release
        txn(32'd7, 32'd11, 64'd100, 1'b0, 1'b0, 5);
        @(posedge clk);
        @(negedge clk);
        check_bit("release_in_ready", bus.in_ready, 1'b1);
        check_bit("release_out_valid", bus.out_valid, 1'b0);

        // reset during the 10th MUL cycle discards the transaction
        txn(32'd3, 32'd5, 64'd5, 1'b0, 1'b0, 0);
        drive_accept(32'd9, 32'd9, 64'd9, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        m_acc    = '0;
        m_sticky = 1'b0;
        check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
        check_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_out", bus.out, 64'h0);
        txn(32'd4, 32'd5, 64'd0, 1'b1, 1'b0, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [ACC_W-1:0] rc;
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rc = {32'($urandom), 32'($urandom)};
            txn(ra, rb, rc, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", ACC_W'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_seq
